// File: rtl/line_window_cache_pkg.sv
// Shared types and helpers for the line window cache.
//   word_t      : 32-bit memory word (4 pixels)
//   byte_swap   : reverses the byte order of a word (pixel order fix-up)
//   frame_words : number of memory words in a WxH frame
//   row_words   : number of memory words in one row of width W
package line_cache_pkg;

    typedef logic [31:0] word_t;

    function automatic word_t byte_swap(input word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic int frame_words(input int w, input int h);
        return (w * h) / 4;
    endfunction

    function automatic int row_words(input int w);
        return w / 4;
    endfunction

endpackage

// File: rtl/line_window_cache_if.sv
// Memory bus plus read/write request handshakes of the line window cache.
//   master : cache side (drives memory port and the acks)
//   slave  : environment side (memory model and requesters)
interface line_window_cache_if #(
    parameter int ADDR_W = 16
);
    import line_cache_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    word_t             mem_do;
    word_t             mem_di;
    logic              mem_en;
    logic              mem_we;
    logic              rd_req;
    logic              rd_ack;
    logic              wr_req;
    logic              wr_ack;
    word_t             di;

    modport master (
        output mem_addr, mem_di, mem_en, mem_we, rd_ack, wr_ack,
        input  mem_do, rd_req, wr_req, di
    );

    modport slave (
        input  mem_addr, mem_di, mem_en, mem_we, rd_ack, wr_ack,
        output mem_do, rd_req, wr_req, di
    );

endinterface

// File: rtl/line_window_cache_delay.sv
// One row of delay: a circular RAM of DEPTH words with a single pointer.
//   clk, rst : clock, synchronous active-high pointer reset
//   adv      : shift one position (write din, move pointer)
//   din      : word entering the delay
//   dout     : word written DEPTH advances ago (read before write)
module line_delay #(
    parameter int DEPTH = 88,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DW-1:0] ram [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    // NOTE: the RAM has no reset; stale words are masked downstream by win_ok.
    always_ff @(posedge clk) begin
        if (adv) ram[ptr_q] <= din;
    end

    assign dout = ram[ptr_q];

endmodule

// File: rtl/line_window_cache.sv
// Streams a frame in raster order from word memory, keeps ROWS-1 previous
// rows in line delays and presents a vertical column of ROWS words with its
// position. Also writes result words back to a second frame region.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : memory port and rd/wr request handshakes (master side)
//   col_valid : col_data/col_x/row_y valid (one cycle per returned word)
//   col_data  : slice k = word from k rows above, slice 0 = current row
//   win_ok    : every slice holds real frame data
//   col_x     : word column, row_y : row of slice 0
//   rd_done   : whole frame requested, wr_done : whole frame written
//   finish    : synchronous clear of pointers, counters and pipeline
module line_window_cache
    import line_cache_pkg::*;
#(
    parameter int WIDTH   = 352,
    parameter int HEIGHT  = 288,
    parameter int ROWS    = 3,
    parameter int ADDR_W  = 16,
    parameter int WR_BASE = WIDTH * HEIGHT / 4
) (
    input  logic                         clk,
    input  logic                         rst,
    line_window_cache_if.master          bus,
    output logic                         col_valid,
    output logic [ROWS*32-1:0]           col_data,
    output logic                         win_ok,
    output logic [$clog2(WIDTH/4)-1:0]   col_x,
    output logic [$clog2(HEIGHT)-1:0]    row_y,
    output logic                         rd_done,
    output logic                         wr_done,
    input  logic                         finish
);
    localparam int MAX_ADDR = frame_words(WIDTH, HEIGHT);
    localparam int ROW_W    = row_words(WIDTH);
    localparam int XW       = $clog2(WIDTH / 4);
    localparam int YW       = $clog2(HEIGHT);

    localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(MAX_ADDR - 1);
    localparam logic [ADDR_W-1:0] WR_FIRST = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(WR_BASE + MAX_ADDR - 1);
    localparam logic [XW-1:0]     X_LAST   = XW'(ROW_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(HEIGHT - 1);
    localparam logic [YW-1:0]     Y_FULL   = YW'(ROWS - 1);

    logic clear;
    logic rd_ack, wr_ack;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    word_t             mem_di_q,   mem_di_d;
    logic              mem_en_q,   mem_en_d;
    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic              rd_done_q,  rd_done_d;
    logic              wr_done_q,  wr_done_d;
    // Position of the next request, then two stages travelling with it.
    logic [XW-1:0]     x_q,  x_d,  x1_q, x1_d, x2_q, x2_d;
    logic [YW-1:0]     y_q,  y_d,  y1_q, y1_d, y2_q, y2_d;
    logic              v1_q, v1_d, v2_q, v2_d;

    assign clear = rst | finish;

    // Write has priority; nothing is accepted while a clear is pending.
    assign wr_ack = bus.wr_req & ~wr_done_q & ~clear;
    assign rd_ack = bus.rd_req & ~wr_ack & ~rd_done_q & ~clear;

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_done_d  = rd_done_q;
        wr_done_d  = wr_done_q;
        x_d        = x_q;
        y_d        = y_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        v1_d       = 1'b0;
        v2_d       = v1_q;
        x2_d       = v1_q ? x1_q : x2_q;
        y2_d       = v1_q ? y1_q : y2_q;

        if (wr_ack) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = wr_ptr_q;
            mem_di_d   = byte_swap(bus.di);
            wr_ptr_d   = wr_ptr_q + 1'b1;
            if (wr_ptr_q == WR_LAST) wr_done_d = 1'b1;
        end else if (rd_ack) begin
            mem_en_d   = 1'b1;
            mem_addr_d = rd_ptr_q;
            rd_ptr_d   = rd_ptr_q + 1'b1;
            if (rd_ptr_q == RD_LAST) rd_done_d = 1'b1;
            v1_d = 1'b1;
            x1_d = x_q;
            y1_d = y_q;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            mem_addr_q <= '0;
            mem_di_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= WR_FIRST;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
        end
    end

    // Slice 0 is the word returning from memory this cycle; slice k+1 is the
    // output of delay k, which is fed by slice k, forming one chain.
    word_t slice [ROWS];
    assign slice[0] = byte_swap(bus.mem_do);

    for (genvar g = 0; g < ROWS - 1; g++) begin : g_delay
        line_delay #(
            .DEPTH (ROW_W),
            .DW    (32)
        ) u_delay (
            .clk  (clk),
            .rst  (clear),
            .adv  (v2_q),
            .din  (slice[g]),
            .dout (slice[g+1])
        );
    end

    for (genvar k = 0; k < ROWS; k++) begin : g_col
        assign col_data[k*32 +: 32] = slice[k];
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_di   = mem_di_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.rd_ack   = rd_ack;
    assign bus.wr_ack   = wr_ack;

    assign col_valid = v2_q;
    assign col_x     = x2_q;
    assign row_y     = y2_q;
    assign win_ok    = v2_q & (y2_q >= Y_FULL);
    assign rd_done   = rd_done_q;
    assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_line_window_cache.sv
// Self-checking bench for line_window_cache on a 16x4 frame, ROWS=3.
module tb_line_window_cache;
    import line_cache_pkg::*;

    localparam int WIDTH   = 16;
    localparam int HEIGHT  = 4;
    localparam int ROWS    = 3;
    localparam int ADDR_W  = 16;
    localparam int ROW_W   = WIDTH / 4;
    localparam int MAX     = WIDTH * HEIGHT / 4;
    localparam int WR_BASE = MAX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic finish = 1'b0;
    always #5 clk = ~clk;

    line_window_cache_if #(.ADDR_W(ADDR_W)) bus ();

    logic                 col_valid, win_ok, rd_done, wr_done;
    logic [ROWS*32-1:0]   col_data;
    logic [1:0]           col_x, row_y;

    line_window_cache #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ROWS    (ROWS),
        .ADDR_W  (ADDR_W),
        .WR_BASE (WR_BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .col_valid (col_valid),
        .col_data  (col_data),
        .win_ok    (win_ok),
        .col_x     (col_x),
        .row_y     (row_y),
        .rd_done   (rd_done),
        .wr_done   (wr_done),
        .finish    (finish)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous memory: read word i holds value i, write region captured.
    word_t rmem [64];
    word_t wmem [64];
    initial for (int i = 0; i < 64; i++) rmem[i] = word_t'(i);

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) wmem[bus.mem_addr[5:0]] <= bus.mem_di;
            else            bus.mem_do <= rmem[bus.mem_addr[5:0]];
        end
    end

    // Reference model: counts accepted words, queues read indices, and
    // derives every expected output from the frame geometry.
    typedef enum {EV_RST, EV_WR, EV_RD, EV_IDLE} ev_e;
    ev_e   prev_ev  = EV_RST;
    int    rd_cnt   = 0;
    int    wr_cnt   = 0;
    int    exp_addr = 0;
    word_t exp_di   = '0;
    int    pend [$];
    int    cv_cnt   = 0;
    bit    mon_en   = 1'b0;

    always @(negedge clk) begin
        bit e_wr, e_rd;
        int idx;
        if (mon_en) begin
            case (prev_ev)
                EV_RST: begin
                    exp_addr = 0;
                    exp_di   = '0;
                    check("m_en_rst", 128'(bus.mem_en), 128'(0));
                    check("m_we_rst", 128'(bus.mem_we), 128'(0));
                end
                EV_WR: begin
                    check("m_en_wr", 128'(bus.mem_en), 128'(1));
                    check("m_we_wr", 128'(bus.mem_we), 128'(1));
                end
                EV_RD: begin
                    check("m_en_rd", 128'(bus.mem_en), 128'(1));
                    check("m_we_rd", 128'(bus.mem_we), 128'(0));
                end
                default: begin
                    check("m_en_idle", 128'(bus.mem_en), 128'(0));
                    check("m_we_idle", 128'(bus.mem_we), 128'(0));
                end
            endcase
            check("m_addr", 128'(bus.mem_addr), 128'(exp_addr));
            check("m_di", 128'(bus.mem_di), 128'(exp_di));

            e_wr = bus.wr_req && (wr_cnt < MAX) && !rst && !finish;
            e_rd = bus.rd_req && !e_wr && (rd_cnt < MAX) && !rst && !finish;
            check("wr_ack", 128'(bus.wr_ack), 128'(e_wr));
            check("rd_ack", 128'(bus.rd_ack), 128'(e_rd));
            check("wr_done", 128'(wr_done), 128'(wr_cnt == MAX));
            check("rd_done", 128'(rd_done), 128'(rd_cnt == MAX));

            if (col_valid) begin
                if (pend.size() == 0) begin
                    check("col_valid_unexpected", 128'(col_valid), 128'(0));
                end else begin
                    idx = pend.pop_front();
                    cv_cnt++;
                    check("col_x", 128'(col_x), 128'(idx % ROW_W));
                    check("row_y", 128'(row_y), 128'(idx / ROW_W));
                    check("win_ok", 128'(win_ok), 128'((idx / ROW_W) >= ROWS - 1));
                    for (int k = 0; k < ROWS; k++) begin
                        if (idx >= k * ROW_W)
                            check($sformatf("slice%0d_i%0d", k, idx),
                                  128'(col_data[k*32 +: 32]),
                                  128'(byte_swap(word_t'(idx - k * ROW_W))));
                    end
                end
            end else begin
                check("win_ok_idle", 128'(win_ok), 128'(0));
            end

            if (rst || finish) begin
                rd_cnt  = 0;
                wr_cnt  = 0;
                pend.delete();
                prev_ev = EV_RST;
            end else if (e_wr) begin
                prev_ev  = EV_WR;
                exp_addr = WR_BASE + wr_cnt;
                exp_di   = byte_swap(bus.di);
                wr_cnt++;
            end else if (e_rd) begin
                prev_ev  = EV_RD;
                exp_addr = rd_cnt;
                pend.push_back(rd_cnt);
                rd_cnt++;
            end else begin
                prev_ev = EV_IDLE;
            end
        end
    end

    task automatic do_finish();
        @(posedge clk); #1 finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0;
    endtask

    word_t di_vals [3];
    bit    seen;

    initial begin
        di_vals[0] = 32'h11223344;
        di_vals[1] = 32'hA1B2C3D4;
        di_vals[2] = 32'h0F1E2D3C;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        bus.di     = '0;

        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_mem_en",   128'(bus.mem_en),   128'(0));
        check("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        check("rst_col_valid", 128'(col_valid),   128'(0));
        check("rst_col_x",    128'(col_x),        128'(0));
        check("rst_row_y",    128'(row_y),        128'(0));
        check("rst_rd_done",  128'(rd_done),      128'(0));
        check("rst_wr_done",  128'(wr_done),      128'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Continuous reads: latency and first full window.
        cv_cnt = 0;
        bus.rd_req = 1'b1;
        @(negedge clk); check("first_rd_ack", 128'(bus.rd_ack), 128'(1));
        @(negedge clk); check("lat_cyc1_cv", 128'(col_valid), 128'(0));
        @(negedge clk); check("lat_cyc2_cv", 128'(col_valid), 128'(1));
        check("first_col_x", 128'(col_x), 128'(0));
        check("first_row_y", 128'(row_y), 128'(0));
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (col_valid && win_ok) seen = 1'b1;
        end
        check("win_ok_seen", 128'(seen), 128'(1));
        check("win_first_y", 128'(row_y), 128'(2));
        check("win_first_x", 128'(col_x), 128'(0));
        check("win_first_data", 128'(col_data),
              128'({byte_swap(32'h0), byte_swap(32'h4), byte_swap(32'h8)}));
        for (int c = 0; c < 40 && !rd_done; c++) @(negedge clk);
        check("frame1_rd_done", 128'(rd_done), 128'(1));
        @(posedge clk); #1 bus.rd_req = 1'b0;
        repeat (4) @(negedge clk);
        check("frame1_cols", 128'(cv_cnt), 128'(MAX));

        // Same frame with randomly stalled requests.
        do_finish();
        cv_cnt = 0;
        for (int c = 0; c < 400 && !rd_done; c++) begin
            bus.rd_req = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.rd_req = 1'b0;
        check("frame2_rd_done", 128'(rd_done), 128'(1));
        repeat (4) @(negedge clk);
        check("frame2_cols", 128'(cv_cnt), 128'(MAX));

        // Read/write collision: write wins for three cycles.
        do_finish();
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.di = di_vals[k];
            @(negedge clk);
            check($sformatf("coll_wr_ack%0d", k), 128'(bus.wr_ack), 128'(1));
            check($sformatf("coll_rd_ack%0d", k), 128'(bus.rd_ack), 128'(0));
            if (k > 0) begin
                check($sformatf("coll_addr%0d", k - 1), 128'(bus.mem_addr), 128'(WR_BASE + k - 1));
                check($sformatf("coll_we%0d", k - 1), 128'(bus.mem_we), 128'(1));
            end
            if (k == 1) check("di_swap", 128'(bus.mem_di), 128'(32'h44332211));
            @(posedge clk); #1;
        end
        bus.wr_req = 1'b0;
        @(negedge clk);
        check("coll_addr2", 128'(bus.mem_addr), 128'(WR_BASE + 2));
        check("coll_di2", 128'(bus.mem_di), 128'(byte_swap(di_vals[2])));
        check("read_after_wr", 128'(bus.rd_ack), 128'(1));
        @(posedge clk); #1 bus.rd_req = 1'b0;
        @(negedge clk);
        check("read_after_wr_addr", 128'(bus.mem_addr), 128'(0));
        check("read_after_wr_we", 128'(bus.mem_we), 128'(0));

        // Fill the write region and probe past the end.
        bus.wr_req = 1'b1;
        for (int c = 0; c < 40 && !wr_done; c++) begin
            bus.di = $urandom;
            @(posedge clk); #1;
        end
        check("wr_done_set", 128'(wr_done), 128'(1));
        @(negedge clk); check("wr_ack_after_done", 128'(bus.wr_ack), 128'(0));
        @(posedge clk); #1 bus.wr_req = 1'b0;
        @(negedge clk); check("mem_en_after_done", 128'(bus.mem_en), 128'(0));
        check("wmem_first", 128'(wmem[WR_BASE]), 128'(32'h44332211));

        // Finish one cycle after an accepted read discards it.
        do_finish();
        bus.rd_req = 1'b1;
        @(negedge clk); check("pre_finish_ack", 128'(bus.rd_ack), 128'(1));
        @(posedge clk); #1 begin bus.rd_req = 1'b0; finish = 1'b1; end
        @(posedge clk); #1 finish = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (col_valid) seen = 1'b1;
        end
        check("no_cv_after_finish", 128'(seen), 128'(0));
        @(posedge clk); #1 bus.rd_req = 1'b1;
        @(negedge clk); check("restart_ack", 128'(bus.rd_ack), 128'(1));
        @(negedge clk); check("restart_addr", 128'(bus.mem_addr), 128'(0));
        @(negedge clk);
        check("restart_cv", 128'(col_valid), 128'(1));
        check("restart_row_y", 128'(row_y), 128'(0));
        check("restart_win_ok", 128'(win_ok), 128'(0));
        for (int c = 0; c < 40 && !rd_done; c++) @(negedge clk);
        check("frame3_rd_done", 128'(rd_done), 128'(1));
        @(posedge clk); #1 bus.rd_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
